// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Holds the fetch FSM state encoding and the prefetch queue entry layout.
package fetch_pkg;

   localparam int unsigned WORD_W        = 32;
   localparam int unsigned DEFAULT_DEPTH = 4;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWait,
      StDrop
   } fetchState_e;

   typedef struct packed {
      logic [WORD_W-1:0] inst;
      logic [WORD_W-1:0] pcPlusOne;
   } queueEntry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Prefetch queue: power-of-two circular buffer of {instruction, PC+1} entries.
// Head entry is presented combinationally and reads as zero when the queue is empty.
module prefetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    push,
   input  queueEntry_t             pushEntry,
   input  logic                    pop,
   output logic                    headValid,
   output queueEntry_t             headEntry,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

   queueEntry_t     store [DEPTH];
   logic [PtrW-1:0] wrPtr;
   logic [PtrW-1:0] rdPtr;
   logic [CntW-1:0] countQ;
   logic            doPush;
   logic            doPop;

   assign doPop  = pop && (countQ != '0);
   assign doPush = push && ((countQ != FullCnt) || doPop);

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wrPtr  <= '0;
         rdPtr  <= '0;
         countQ <= '0;
      end else begin
         if (doPush) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (doPop) begin
            rdPtr <= rdPtr + 1'b1;
         end
         if (doPush && !doPop) begin
            countQ <= countQ + 1'b1;
         end else if (doPop && !doPush) begin
            countQ <= countQ - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) begin
         store[wrPtr] <= pushEntry;
      end
   end

   assign headValid = (countQ != '0);
   assign headEntry = headValid ? store[rdPtr] : '0;
   assign count     = countQ;

endmodule

// File: rtl/instruction_prefetch_unit.sv
// Fetch stage ahead of IF/ID: owns the PC, runs a single-outstanding memory read
// handshake and feeds a prefetch queue; taken-branch redirects flush and refetch.
module instruction_prefetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned       DEPTH    = DEFAULT_DEPTH,
   parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              redirect,
   input  logic [WORD_W-1:0] redirect_pc,
   output logic              inst_valid,
   output logic [WORD_W-1:0] inst_out,
   output logic [WORD_W-1:0] pc_plus_one_out,
   output logic              mem_req,
   output logic [WORD_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [WORD_W-1:0] mem_rdata
);

   localparam int unsigned     CntW     = $clog2(DEPTH) + 1;
   localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

   fetchState_e       state;
   logic [WORD_W-1:0] fetchPc;
   logic [CntW-1:0]   count;
   logic              headValid;
   queueEntry_t       headEntry;
   queueEntry_t       pushEntry;
   logic              pushEn;
   logic              popEn;
   logic              hasRoom;

   // A granted-but-unreturned word already owns a slot.
   assign hasRoom = (count + CntW'(state == StWait)) < DepthCnt;

   assign popEn  = headValid && !stall && !redirect;
   assign pushEn = (state == StWait) && mem_rvalid && !redirect;

   // fetchPc advanced on grant and is frozen in StWait, so it is the granted PC+1.
   assign pushEntry = '{inst: mem_rdata, pcPlusOne: fetchPc};

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= StReq;
         fetchPc <= RESET_PC;
      end else begin
         unique case (state)
            StIdle: begin
               if (redirect) begin
                  state   <= StReq;
                  fetchPc <= redirect_pc;
               end else if (hasRoom) begin
                  state <= StReq;
               end
            end
            StReq: begin
               if (redirect) begin
                  fetchPc <= redirect_pc;
                  state   <= mem_gnt ? StDrop : StReq;
               end else if (mem_gnt) begin
                  fetchPc <= fetchPc + 32'd1;
                  state   <= StWait;
               end
            end
            StWait: begin
               if (redirect) begin
                  fetchPc <= redirect_pc;
                  state   <= mem_rvalid ? StReq : StDrop;
               end else if (mem_rvalid) begin
                  state <= hasRoom ? StReq : StIdle;
               end
            end
            StDrop: begin
               if (redirect) begin
                  fetchPc <= redirect_pc;
               end
               if (mem_rvalid) begin
                  state <= StReq;
               end
            end
            default: state <= StReq;
         endcase
      end
   end

   prefetch_fifo #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect),
      .push      (pushEn),
      .pushEntry (pushEntry),
      .pop       (popEn),
      .headValid (headValid),
      .headEntry (headEntry),
      .count     (count)
   );

   assign mem_req         = (state == StReq);
   assign mem_addr        = redirect ? redirect_pc : fetchPc;
   assign inst_valid      = headValid;
   assign inst_out        = headEntry.inst;
   assign pc_plus_one_out = headEntry.pcPlusOne;

endmodule
